// File: rtl/hub75_fb_rowreader_if.sv
// Frame-buffer access bundle between the row reader and the SPRAM arbiter:
// req/gnt/rel handshake plus the read address and read data.
interface hub75_fb_rowreader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              ctrl_req;
  logic              ctrl_gnt;
  logic              ctrl_rel;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  modport master (output ctrl_req, ctrl_rel, fb_addr, input ctrl_gnt, fb_data);
  modport slave  (input ctrl_req, ctrl_rel, fb_addr, output ctrl_gnt, fb_data);
endinterface

// File: rtl/hub75_fb_rowreader.sv
// HUB75 row read-out: fetches one row of every bank from the shared frame buffer
// and fills a double-buffered line buffer with per-channel bit-plane values.
//   state | meaning
//   IDLE  | waiting for rd_row_load
//   REQ   | ctrl_req high until ctrl_gnt
//   READ  | one frame-buffer address per cycle, {bank, col, word} counter
//   FLUSH | captures the data word for the last address
//   REL   | one-cycle ctrl_rel
module hub75_fb_rowreader #(
  parameter int N_BANKS  = 2,
  parameter int N_ROWS   = 32,
  parameter int N_COLS   = 64,
  parameter int N_CHANS  = 3,
  parameter int N_PLANES = 8,
  parameter int BITDEPTH = 24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [$clog2(N_ROWS)-1:0]            rd_row_addr,
  input  logic                                 rd_row_load,
  output logic                                 rd_row_rdy,
  input  logic                                 rd_row_swap,
  output logic [N_BANKS*N_CHANS*N_PLANES-1:0]  rd_data,
  input  logic [$clog2(N_COLS)-1:0]            rd_col_addr,
  input  logic                                 rd_en,
  hub75_fb_rowreader_if.master                 fb
);
  localparam int LOG_N_BANKS     = $clog2(N_BANKS);
  localparam int LOG_N_ROWS      = $clog2(N_ROWS);
  localparam int LOG_N_COLS      = $clog2(N_COLS);
  localparam int LOG_BITDEPTH    = ($clog2(BITDEPTH) > 2) ? $clog2(BITDEPTH) : 2;
  localparam int SPRAM_EXP       = 1 + LOG_N_BANKS + LOG_N_ROWS + LOG_N_COLS + LOG_BITDEPTH - 18;
  localparam int LOG_SPRAM_COUNT = (SPRAM_EXP > 0) ? SPRAM_EXP : 0;
  localparam int PIX_W           = 1 << LOG_BITDEPTH;
  localparam int FB_DW           = ((16 << LOG_SPRAM_COUNT) < PIX_W) ? (16 << LOG_SPRAM_COUNT) : PIX_W;
  localparam int FB_DC           = PIX_W / FB_DW;
  localparam int LOG_FB_DC       = $clog2(FB_DC);
  localparam int FB_AW           = 1 + LOG_N_BANKS + LOG_N_ROWS + LOG_N_COLS + LOG_FB_DC;
  localparam int WW              = (LOG_FB_DC > 0) ? LOG_FB_DC : 1;
  localparam int LOW_W           = LOG_N_COLS + LOG_FB_DC;
  localparam int CNT_W           = LOG_N_BANKS + LOW_W;
  localparam int SL_W            = N_CHANS * N_PLANES;
  localparam int LB_W            = N_BANKS * SL_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BANKS * N_COLS * FB_DC - 1);
  localparam logic [PIX_W-1:0] SLOT     = PIX_W'({FB_DW{1'b1}});

  localparam int R_W  = (BITDEPTH == 24) ? 8  : (BITDEPTH == 16) ? 5  : 3;
  localparam int G_W  = (BITDEPTH == 24) ? 8  : (BITDEPTH == 16) ? 6  : 3;
  localparam int B_W  = (BITDEPTH == 24) ? 8  : (BITDEPTH == 16) ? 5  : 2;
  localparam int R_LO = 0;
  localparam int G_LO = R_W;
  localparam int B_LO = R_W + G_W;

  typedef enum logic [2:0] {IDLE, REQ, READ, FLUSH, REL} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_d;
  logic                   valid_d;
  logic [LOG_N_ROWS-1:0]  row_q;
  logic                   wbuf, front;
  logic [PIX_W-1:0]       pix_acc, pix_full;
  logic [WW-1:0]          word_d;
  logic [LOG_N_COLS-1:0]  col_d;
  logic [LOG_N_BANKS-1:0] bank_d;
  logic                   lb_we;
  logic [SL_W-1:0]        slice;
  logic [LB_W-1:0]        lbuf [2*N_COLS];

  // Narrow channels are left-aligned and their bits repeated MSB-first into the LSBs.
  function automatic logic [N_PLANES-1:0] to_planes(input logic [7:0] ch, input int w);
    logic [N_PLANES-1:0] r;
    r = '0;
    for (int i = 0; i < N_PLANES; i++)
      r = r | (N_PLANES'((ch >> (w - 1 - (i % w))) & 8'd1) << (N_PLANES - 1 - i));
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cnt_d   <= '0;
      valid_d <= 1'b0;
      row_q   <= '0;
      wbuf    <= 1'b0;
      front   <= 1'b0;
      pix_acc <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cnt_d   <= cnt;
      valid_d <= (state == READ);
      if (rd_row_load && state == IDLE) begin
        row_q <= rd_row_addr;
        wbuf  <= ~front;
      end
      if (rd_row_swap) front <= ~front;
      if (valid_d) pix_acc <= pix_full;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rd_row_rdy    = 1'b0;
    fb.ctrl_req   = 1'b0;
    fb.ctrl_rel   = 1'b0;
    fb.fb_addr    = '0;
    case (state)
      IDLE: begin
        rd_row_rdy = 1'b1;
        if (rd_row_load) state_nxt = REQ;
      end
      REQ: begin
        fb.ctrl_req = 1'b1;
        if (fb.ctrl_gnt) begin
          state_nxt = READ;
          cnt_nxt   = '0;
        end
      end
      READ: begin
        fb.fb_addr = {cnt[CNT_W-1:LOW_W], row_q, cnt[LOW_W-1:0]};
        cnt_nxt    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end
      end
      FLUSH: state_nxt = REL;
      REL: begin
        fb.ctrl_rel = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data returns one cycle after its address, so decode uses the delayed counter.
  assign word_d = WW'(cnt_d) & WW'(FB_DC - 1);
  assign col_d  = LOG_N_COLS'(cnt_d >> LOG_FB_DC);
  assign bank_d = cnt_d[CNT_W-1:LOW_W];
  assign lb_we  = valid_d && (word_d == WW'(FB_DC - 1));

  always_comb begin
    pix_full = pix_acc & ~(SLOT << (int'(word_d) * FB_DW));
    pix_full = pix_full | (PIX_W'(fb.fb_data) << (int'(word_d) * FB_DW));
  end

  assign slice = {to_planes(8'(pix_full >> B_LO), B_W),
                  to_planes(8'(pix_full >> G_LO), G_W),
                  to_planes(8'(pix_full >> R_LO), R_W)};

  always_ff @(posedge clk) begin
    if (lb_we) begin
      for (int b = 0; b < N_BANKS; b++)
        if (int'(bank_d) == b) lbuf[{wbuf, col_d}][b*SL_W +: SL_W] <= slice;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= lbuf[{front, rd_col_addr}];
  end
endmodule

// File: tb/tb_hub75_fb_rowreader.sv
// Directed bench for hub75_fb_rowreader: an RGB888 instance and an RGB565 instance,
// each fed from a small frame-buffer memory model.
module tb_hub75_fb_rowreader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  row24, row16;
  logic        load24, load16, rdy24, rdy16, swap24, swap16, en24, en16;
  logic [5:0]  col24, col16;
  logic [47:0] data24, data16;

  hub75_fb_rowreader_if #(.ADDR_W(13), .DATA_W(16)) fb24 ();
  hub75_fb_rowreader_if #(.ADDR_W(12), .DATA_W(16)) fb16 ();

  hub75_fb_rowreader dut24 (
    .clk(clk), .rst(rst), .rd_row_addr(row24), .rd_row_load(load24), .rd_row_rdy(rdy24),
    .rd_row_swap(swap24), .rd_data(data24), .rd_col_addr(col24), .rd_en(en24), .fb(fb24));

  hub75_fb_rowreader #(.BITDEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .rd_row_addr(row16), .rd_row_load(load16), .rd_row_rdy(rdy16),
    .rd_row_swap(swap16), .rd_data(data16), .rd_col_addr(col16), .rd_en(en16), .fb(fb16));

  logic [15:0] mem24 [0:8191];
  logic [15:0] mem16 [0:4095];
  always @(posedge clk) begin
    fb24.fb_data <= mem24[fb24.fb_addr];
    fb16.fb_data <= mem16[fb16.fb_addr];
  end

  int rel24 = 0;
  always @(posedge clk) if (fb24.ctrl_rel) rel24 <= rel24 + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { int bank; int row; int col; logic [23:0] pix; } px_t;
  typedef struct { int col; logic [47:0] exp; } rv_t;

  px_t px24 [7];
  px_t px16 [4];
  rv_t rv24a [4];
  rv_t rv24b [2];
  rv_t rv16 [2];

  task automatic fetch24(input int row, input int poke_k, input int swap_k, input int rd_k,
                         input int rd_col, input logic [47:0] rd_exp, input int rst_k);
    int rel0;
    rel0 = rel24;
    row24 = 5'(row);
    load24 = 1'b1;
    @(negedge clk);
    load24 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("req_held", fb24.ctrl_req, 1);
      chk("rdy_busy", rdy24, 0);
      if (i < 2) @(negedge clk);
    end
    fb24.ctrl_gnt = 1'b1;
    @(negedge clk);
    fb24.ctrl_gnt = 1'b0;
    chk("req_drop", fb24.ctrl_req, 0);
    for (int k = 0; k < 256; k++) begin
      chk("fb_addr", fb24.fb_addr, 64'((k >> 7) * 4096 + row * 128 + (k & 127)));
      if (rd_k >= 0 && k == rd_k + 1) chk("rd_during_fetch", data24, rd_exp);
      load24 = 1'b0;
      swap24 = 1'b0;
      en24   = 1'b0;
      if (k == poke_k) load24 = 1'b1;
      if (k == swap_k) swap24 = 1'b1;
      if (k == rd_k) begin
        en24  = 1'b1;
        col24 = 6'(rd_col);
      end
      if (k == rst_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy", rdy24, 1);
        chk("rst_req", fb24.ctrl_req, 0);
        chk("rst_addr", fb24.fb_addr, 0);
        chk("rst_data", data24, 0);
        repeat (4) @(negedge clk);
        chk("rst_no_rel", 64'(rel24 - rel0), 0);
        chk("rst_idle", rdy24, 1);
        return;
      end
      @(negedge clk);
    end
    load24 = 1'b0;
    swap24 = 1'b0;
    en24   = 1'b0;
    chk("flush_addr", fb24.fb_addr, 0);
    chk("flush_rel", fb24.ctrl_rel, 0);
    @(negedge clk);
    chk("rel_pulse", fb24.ctrl_rel, 1);
    chk("rel_rdy", rdy24, 0);
    @(negedge clk);
    chk("rel_end", fb24.ctrl_rel, 0);
    chk("rdy_back", rdy24, 1);
    chk("rel_count", 64'(rel24 - rel0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    int a;
    px24[0] = '{0, 5, 7,  24'h80FF01};
    px24[1] = '{1, 5, 7,  24'h123456};
    px24[2] = '{0, 5, 0,  24'hC0FFEE};
    px24[3] = '{1, 5, 63, 24'h00FF00};
    px24[4] = '{0, 5, 63, 24'h0A0B0C};
    px24[5] = '{0, 9, 3,  24'h010203};
    px24[6] = '{1, 9, 3,  24'h000080};
    rv24a[0] = '{7,  48'h123456_80FF01};
    rv24a[1] = '{0,  48'h000000_C0FFEE};
    rv24a[2] = '{10, 48'h000000_000000};
    rv24a[3] = '{63, 48'h00FF00_0A0B0C};
    rv24b[0] = '{3,  48'h000080_010203};
    rv24b[1] = '{7,  48'h000000_000000};
    px16[0] = '{0, 2, 1, 24'h00F81F};
    px16[1] = '{1, 2, 1, 24'h0007E0};
    px16[2] = '{0, 2, 2, 24'h000821};
    px16[3] = '{1, 2, 2, 24'h000016};
    rv16[0] = '{1, 48'h00FF00_FF00FF};
    rv16[1] = '{2, 48'h0000B5_080408};

    for (int i = 0; i < 8192; i++) mem24[i] = 16'h0;
    for (int i = 0; i < 4096; i++) mem16[i] = 16'h0;
    foreach (px24[i]) begin
      a = px24[i].bank * 4096 + px24[i].row * 128 + px24[i].col * 2;
      mem24[a]     = px24[i].pix[15:0];
      mem24[a + 1] = {8'h5A, px24[i].pix[23:16]};
    end
    foreach (px16[i]) mem16[px16[i].bank * 2048 + px16[i].row * 64 + px16[i].col] = px16[i].pix[15:0];

    rst = 1'b1;
    {load24, load16, swap24, swap16, en24, en16} = '0;
    row24 = '0; row16 = '0; col24 = '0; col16 = '0;
    fb24.ctrl_gnt = 1'b0;
    fb16.ctrl_gnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", rdy24, 1);
    chk("reset_req", fb24.ctrl_req, 0);
    chk("reset_rel", fb24.ctrl_rel, 0);
    chk("reset_data", data24, 0);
    chk("reset_addr", fb24.fb_addr, 0);
    chk("reset_rdy16", rdy16, 1);
    chk("reset_data16", data16, 0);
    rst = 1'b0;
    @(negedge clk);

    // Row 5 with a load pulse during READ that must be ignored.
    fetch24(5, 100, -1, -1, 0, 48'h0, -1);
    swap24 = 1'b1;
    @(negedge clk);
    swap24 = 1'b0;
    foreach (rv24a[i]) begin
      en24  = 1'b1;
      col24 = 6'(rv24a[i].col);
      @(negedge clk);
      en24 = 1'b0;
      chk("rd_row5", data24, rv24a[i].exp);
    end
    col24 = 6'd0;
    repeat (2) @(negedge clk);
    chk("rd_hold", data24, rv24a[3].exp);

    // Row 9: front read mid-fetch, then a swap mid-fetch that must not move the write buffer.
    fetch24(9, -1, 30, 20, 7, 48'h123456_80FF01, -1);
    foreach (rv24b[i]) begin
      en24  = 1'b1;
      col24 = 6'(rv24b[i].col);
      @(negedge clk);
      en24 = 1'b0;
      chk("rd_row9", data24, rv24b[i].exp);
    end

    // Reset in the middle of READ.
    fetch24(5, -1, -1, -1, 0, 48'h0, 50);
    en24  = 1'b1;
    col24 = 6'd3;
    @(negedge clk);
    en24 = 1'b0;
    chk("rd_after_rst", data24, 48'h000080_010203);

    // RGB565 instance: single word per pixel, 128 addresses.
    row16  = 5'd2;
    load16 = 1'b1;
    @(negedge clk);
    load16 = 1'b0;
    chk("req16", fb16.ctrl_req, 1);
    fb16.ctrl_gnt = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      fb16.ctrl_gnt = 1'b0;
      n++;
      if (n == 1) chk("addr16_first", fb16.fb_addr, 12'd128);
    end while (!fb16.ctrl_rel && n < 300);
    chk("fetch16_len", n, 130);
    @(negedge clk);
    swap16 = 1'b1;
    @(negedge clk);
    swap16 = 1'b0;
    foreach (rv16[i]) begin
      en16  = 1'b1;
      col16 = 6'(rv16[i].col);
      @(negedge clk);
      en16 = 1'b0;
      chk("rd_rgb565", data16, rv16[i].exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hub75_fb_rowreader.md
Name: hub75_fb_rowreader

Overview:
- Read-out engine of the HUB75 frame buffer.
- On request, it fetches one display row for every bank from the shared SPRAM frame buffer. It gets the frame buffer through a req/gnt/rel arbiter.
- It converts each pixel into per-channel bit-plane values and stores them in a double-buffered line buffer.
- The panel scan driver reads that line buffer column by column.

Parameters:
- N_BANKS, 2, number of panel banks (rows driven in parallel).
- N_ROWS, 32, rows per bank.
- N_COLS, 64, columns per row.
- N_CHANS, 3, colour channels per pixel (order R, G, B; only 3 is supported).
- N_PLANES, 8, bit-planes per channel delivered on rd_data (1..8).
- BITDEPTH, 24, stored pixel width; 8 (RGB332), 16 (RGB565) and 24 (RGB888) are supported.
- Derived localparams (not overridable):
  - LOG_BITDEPTH = max(2, clog2(BITDEPTH)).
  - LOG_SPRAM_COUNT = max(0, 1+LOG_N_BANKS+LOG_N_ROWS+LOG_N_COLS+LOG_BITDEPTH-18).
  - FB_DW = min(16<<LOG_SPRAM_COUNT, 1<<LOG_BITDEPTH).
  - FB_DC = (1<<LOG_BITDEPTH)/FB_DW; LOG_FB_DC = clog2(FB_DC).
  - FB_AW = 1+LOG_N_BANKS+LOG_N_ROWS+LOG_N_COLS+LOG_FB_DC.
  - With the defaults: FB_DW=16, FB_DC=2, FB_AW=14.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- rd_row_addr  in  LOG_N_ROWS  row to fetch; sampled when rd_row_load is accepted.
- rd_row_load  in  1  start-fetch strobe; accepted only while rd_row_rdy=1.
- rd_row_rdy  out  1  high when idle and able to accept a load.
- rd_row_swap  in  1  strobe that exchanges the front and back line buffers.
- rd_data  out  N_BANKS*N_CHANS*N_PLANES  front-buffer column data.
- rd_col_addr  in  LOG_N_COLS  column to read.
- rd_en  in  1  read strobe.
- ctrl_req  out  1  frame-buffer access request.
- ctrl_gnt  in  1  single-cycle grant pulse.
- ctrl_rel  out  1  single-cycle release pulse.
- fb_addr  out  FB_AW-1  frame-buffer word address, composed as {bank, row, col, word}.
- fb_data  in  FB_DW  frame-buffer read data, valid 1 cycle after fb_addr.

Behaviour:
- Reset values:
  - state IDLE, rd_row_rdy=1, ctrl_req=0, ctrl_rel=0.
  - fb_addr=0, rd_data=0, front-buffer select=0.
  - Line buffer contents are undefined.
- FSM IDLE→REQ:
  - Triggered by rd_row_load with rd_row_rdy=1.
  - Latch rd_row_addr, and latch the write buffer as ~front.
- REQ:
  - ctrl_req=1 and is held until ctrl_gnt.
  - On gnt, ctrl_req drops in the next cycle; go to READ.
- READ:
  - A counter {bank, col, word} runs from 0 to N_BANKS*N_COLS*FB_DC-1, one address per cycle. Word is the fastest-changing field, then col, then bank.
  - fb_addr = {bank, row_latched, col, word}.
  - After the last address, go to FLUSH.
- FLUSH: 1 cycle, to capture the final data word.
- REL: ctrl_rel=1 for exactly 1 cycle, then IDLE.
- rd_row_rdy = (state==IDLE). rd_row_load in any other state is ignored.
- Reset mid-operation aborts to IDLE immediately. No ctrl_rel is issued.
- fb_addr is 0 outside READ.
- Pixel assembly:
  - The word with index w occupies pixel bits [w*FB_DW +: FB_DW], so word 0 is the LSBs; only BITDEPTH bits are used.
  - When the last word of a pixel arrives, write the converted entry to line buffer [write_buf][col], in the slot for that bank.
- Channel extraction:
  - 24: R=[7:0], G=[15:8], B=[23:16].
  - 16: R=[4:0], G=[10:5], B=[15:11].
  - 8: R=[2:0], G=[5:3], B=[7:6].
- Plane conversion:
  - If the channel is at least N_PLANES wide, take its N_PLANES MSBs.
  - If it is narrower, left-align it and fill the LSBs by repeating the channel MSB-first.
  - Examples: 5-bit 0x1F → 0xFF; 2-bit 0b10 → 0xAA.
- rd_data layout: bank b, channel c at rd_data[((b*N_CHANS)+c)*N_PLANES +: N_PLANES].
- Line buffer organisation:
  - 2 × N_COLS entries of the full rd_data width; the top bit of the address is the buffer select.
  - Per-bank write enables let banks be written separately.
- Line buffer reads:
  - rd_en=1 registers front[rd_col_addr] onto rd_data the next cycle.
  - rd_data holds while rd_en=0.
  - The read port is independent of the fetch; reads during a fetch return the front buffer.
- rd_row_swap:
  - Toggles the front-buffer select next cycle, in any state.
  - A fetch in progress keeps writing the buffer latched at load time.
- Fetch duration from gnt to ctrl_rel is N_BANKS*N_COLS*FB_DC+2 cycles; with the defaults, 258.

Test Plan:
- Reset → rd_row_rdy=1, ctrl_req=0, ctrl_rel=0, rd_data=0.
- Load row 5; gnt 3 cycles later → ctrl_req held until gnt.
  - fb_addr sequence with the defaults: {0,5,0,0}, {0,5,0,1}, {0,5,1,0}, … {1,5,63,1}, i.e. 256 addresses.
  - Then a single ctrl_rel pulse, and rd_row_rdy returns to 1.
- Pixel 0x80FF01 (fb_data 0xFF01 then 0x0080) at bank 0, col 7; swap; rd_en with col 7 → next cycle the bank 0 slice is R=0x01, G=0xFF, B=0x80.
- BITDEPTH=16, N_PLANES=8, pixel 0xF81F → R=0xFF, G=0x00, B=0xFF.
- rd_row_load pulsed during READ → ignored; the address sequence is unchanged, and exactly one ctrl_rel is issued.
- rst asserted mid-READ → next cycle IDLE, rd_row_rdy=1, ctrl_req=0, no ctrl_rel.
